// File: rtl/control_conditioner.sv
// Debounces asynchronous buttons/switches into a registered control vector.
// Level channels follow the debounced state; momentary channels emit a press pulse.
module control_conditioner #(
  parameter int WIDTH = 15,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter logic [WIDTH-1:0] PULSE_MASK = 15'h7C00
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] controls,
  output logic             changed
);

  localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] st;
  logic [WIDTH-1:0] st_nxt;
  logic [19:0]      cnt     [WIDTH];
  logic [19:0]      cnt_nxt [WIDTH];

  // Any mismatch-free edge restarts the count, so a bounce discards progress.
  always_comb begin
    st_nxt = st;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != st[i]) begin
        if (cnt[i] >= LAST) begin
          st_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      st       <= '0;
      controls <= '0;
      changed  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= raw_in;
      s2       <= s1;
      st       <= st_nxt;
      controls <= (st_nxt & ~PULSE_MASK)
                | (st_nxt & ~st & PULSE_MASK);
      changed  <= |(st_nxt ^ st);
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_control_conditioner.sv
// Bench for control_conditioner: directed vectors, corner sequences
// and random bouncing inputs against a window-based reference model.
module tb_control_conditioner;

  localparam int W = 15;
  localparam int D = 4;
  localparam logic [W-1:0] MASK = 15'h7C00;

  logic         clk;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] controls;
  logic         changed;

  int checks;
  int errors;

  control_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .PULSE_MASK(MASK)
  ) dut (
    .clock(clk),
    .reset(reset),
    .raw_in(raw_in),
    .controls(controls),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw is seen two edges late; a channel flips once
  // the last D seen samples all disagree with its debounced state.
  logic [W-1:0] pipe [$];
  logic [W-1:0] win  [$];
  logic [W-1:0] m_st;
  logic [W-1:0] m_ctl;
  logic         m_chg;

  task automatic model_edge(input logic [W-1:0] r, input logic rs);
    logic [W-1:0] seen;
    logic [W-1:0] nst;
    logic         all;
    if (rs) begin
      pipe.delete();
      win.delete();
      repeat (2) pipe.push_back('0);
      repeat (D) win.push_back('0);
      m_st  = '0;
      m_ctl = '0;
      m_chg = 1'b0;
      return;
    end
    seen = pipe.pop_front();
    pipe.push_back(r);
    void'(win.pop_front());
    win.push_back(seen);
    nst = m_st;
    for (int i = 0; i < W; i++) begin
      all = 1'b1;
      foreach (win[k]) if (win[k][i] == m_st[i]) all = 1'b0;
      if (all) nst[i] = ~m_st[i];
    end
    m_ctl = (nst & ~MASK) | (nst & ~m_st & MASK);
    m_chg = (nst != m_st);
    m_st  = nst;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] r, input logic rs);
    @(negedge clk);
    raw_in = r;
    reset  = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic step_chk(input logic [W-1:0] r, input logic rs,
                          input string name);
    step(r, rs);
    chk({name, "_ctl"}, 32'(controls), 32'(m_ctl));
    chk({name, "_chg"}, 32'(changed), 32'(m_chg));
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] ctl;
    logic         chg;
  } vec_t;

  vec_t vt [12];

  initial begin
    int rise;
    int pulses;
    int pedge;
    int chgs;
    int e3;
    int e5;
    logic [W-1:0] cur;
    logic         rs;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    raw_in = '0;

    for (int i = 0; i < 3; i++) vt[i] = '{1'b1, 15'h7FFF, 15'h0, 1'b0};
    vt[3] = '{1'b1, 15'h0000, 15'h0, 1'b0};
    for (int i = 4; i < 12; i++) begin
      vt[i].rst = 1'b0;
      vt[i].raw = 15'h0001;
      vt[i].ctl = (i >= 9) ? 15'h0001 : 15'h0000;
      vt[i].chg = (i == 9);
    end
    for (int i = 0; i < 12; i++) begin
      step(vt[i].raw, vt[i].rst);
      chk($sformatf("vec%0d_ctl", i), 32'(controls), 32'(vt[i].ctl));
      chk($sformatf("vec%0d_chg", i), 32'(changed), 32'(vt[i].chg));
    end

    // Bounce: high 3, low 1, then held high
    step(15'h0, 1'b1);
    rise = 0;
    for (int e = 1; e <= 12; e++) begin
      step_chk((e == 4) ? 15'h0 : 15'h1, 1'b0, "bounce");
      if (rise == 0 && controls[0]) rise = e;
    end
    chk("bounce_rise_edge", 32'(rise), 32'd10);

    // Momentary channel held 20 cycles then released 20 cycles
    step(15'h0, 1'b1);
    pulses = 0;
    pedge  = 0;
    chgs   = 0;
    for (int e = 1; e <= 40; e++) begin
      step_chk((e <= 20) ? 15'h4000 : 15'h0, 1'b0, "pulse");
      if (controls[14]) begin
        pulses++;
        pedge = e;
      end
      if (changed) chgs++;
    end
    chk("pulse_count", 32'(pulses), 32'd1);
    chk("pulse_edge", 32'(pedge), 32'd6);
    chk("pulse_changed_count", 32'(chgs), 32'd2);

    // Two channels rising together
    step(15'h0, 1'b1);
    e3   = 0;
    e5   = 0;
    chgs = 0;
    for (int e = 1; e <= 10; e++) begin
      step_chk(15'h0028, 1'b0, "simul");
      if (e3 == 0 && controls[3]) e3 = e;
      if (e5 == 0 && controls[5]) e5 = e;
      if (changed) chgs++;
    end
    chk("simul_bit3_edge", 32'(e3), 32'd6);
    chk("simul_bit5_edge", 32'(e5), 32'd6);
    chk("simul_changed_count", 32'(chgs), 32'd1);

    // Reset mid-count; first post-reset edge is edge 5
    step(15'h0, 1'b1);
    rise = 0;
    for (int e = 1; e <= 14; e++) begin
      step_chk(15'h0004, (e == 4), "rstmid");
      if (rise == 0 && e > 4 && controls[2]) rise = e;
    end
    chk("rstmid_rise_edge", 32'(rise), 32'd10);

    // Random bouncing inputs against the model
    step(15'h0, 1'b1);
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
      rs = ($urandom_range(0, 299) == 0);
      step_chk(cur, rs, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
